nmea_rx_arbiter: RTL and testbench

- Shares one downstream NMEA sentence parser between N_CH UART character receivers. Each receiver has its own baud rate.
- Buffers characters per channel. Arbitrates round-robin at sentence granularity: a grant runs from '$' to LF.
- Streams the granted channel's characters out over a valid/ready handshake with channel tag and framing flags.
- Sits between the char_r receiver array and the checksum/field parser.

---
 rtl/nmea_pkg.sv | 21 ++
 rtl/ch_fifo.sv | 51 +++++
 rtl/nmea_rx_arbiter.sv | 142 ++++++++++++++
 tb/tb_nmea_rx_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
// rtl/nmea_pkg.sv - shared constants, FSM state type and round-robin helper for the NMEA arbiter
package nmea_pkg;

  localparam int N_CH = 10;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Channel visited at position off of a search starting just after last.
  function automatic int rr_index(input int last, input int off, input int n);
    return (last + 1 + off) % n;
  endfunction

endpackage

// File: rtl/ch_fifo.sv
// rtl/ch_fifo.sv - per-channel character FIFO, one push and one pop per cycle
module ch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head,
  output logic       o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];

  // A pop frees the slot the same-cycle push lands in, so full+pop+push is lossless.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_drop = i_push && o_full && !w_pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/nmea_rx_arbiter.sv
// rtl/nmea_rx_arbiter.sv - sentence-granular round-robin arbiter feeding one NMEA parser
// Optional starvation abort enabled by defining NMEA_ARB_TIMEOUT_EN.
module nmea_rx_arbiter
  import nmea_pkg::*;
#(
  parameter int N_CH        = nmea_pkg::N_CH,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 65535,
  localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_CH-1:0][7:0] i_char,
  input  logic [N_CH-1:0]      i_valid,
  output logic [7:0]           o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CW-1:0]        o_ch,
  output logic                 o_sop,
  output logic                 o_eop,
  output logic [N_CH-1:0]      o_overflow,
  input  logic                 i_ovf_clr,
  output logic                 o_abort
);

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_grant;
  logic [CW-1:0]         r_last;
  logic [CW-1:0]         w_sel;
  logic                  w_found;
  logic [N_CH-1:0][7:0]  w_head;
  logic [N_CH-1:0]       w_empty;
  logic [N_CH-1:0]       w_full;
  logic [N_CH-1:0]       w_drop;
  logic [N_CH-1:0]       w_pop;
  logic [N_CH-1:0]       r_ovf;
  logic [7:0]            w_g_head;
  logic                  w_lock_pop;
  logic                  w_timeout;

  assign w_g_head   = w_head[r_grant];
  assign w_lock_pop = o_valid && i_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    // Non-granted channels shed anything that cannot start a sentence.
    assign w_pop[k] = (r_state == LOCK && r_grant == CW'(k)) ? w_lock_pop
                    : (!w_empty[k] && w_head[k] != CH_DOLLAR);

    ch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_valid[k]),
      .i_data  (i_char[k]),
      .i_pop   (w_pop[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k]),
      .o_head  (w_head[k]),
      .o_drop  (w_drop[k])
    );
  end

  always_comb begin
    logic [CW-1:0] v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      v_idx = CW'(rr_index(int'(r_last), i, N_CH));
      if (!w_found && !w_empty[v_idx] && w_head[v_idx] == CH_DOLLAR) begin
        w_found = 1'b1;
        w_sel   = v_idx;
      end
    end
  end

`ifdef NMEA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (r_state != LOCK || w_lock_pop || w_timeout) begin
      r_to_cnt <= '0;
    end else if (w_empty[r_grant]) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == LOCK) && (r_to_cnt == TW'(TIMEOUT_CYC));
`else
  // TIMEOUT_CYC has no effect in this build; the comparison is constant false.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= CW'(N_CH - 1);
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) r_grant <= w_sel;
      if (r_state == LOCK && w_next == IDLE) r_last <= r_grant;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_found) w_next = LOCK;
      LOCK: if ((w_lock_pop && w_g_head == CH_LF) || w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    o_ch    = '0;
    o_sop   = 1'b0;
    o_eop   = 1'b0;
    o_abort = w_timeout;
    if (r_state == LOCK) begin
      o_valid = !w_empty[r_grant] && !w_timeout;
      o_data  = w_g_head;
      o_ch    = r_grant;
      o_sop   = o_valid && (w_g_head == CH_DOLLAR);
      o_eop   = o_valid && (w_g_head == CH_LF);
    end
  end

  // A new drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ovf <= '0;
    else       r_ovf <= (r_ovf & ~{N_CH{i_ovf_clr}}) | w_drop;
  end

  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_nmea_rx_arbiter.sv
// tb/tb_nmea_rx_arbiter.sv - directed self-checking bench for nmea_rx_arbiter
module tb_nmea_rx_arbiter;
  localparam int N  = 10;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0][7:0] chr;
  logic [N-1:0]      vld;
  logic [7:0]        o_data;
  logic              o_valid;
  logic              rdy;
  logic [CW-1:0]     o_ch;
  logic              o_sop;
  logic              o_eop;
  logic [N-1:0]      o_overflow;
  logic              clr;
  logic              o_abort;

  always #5 clk = ~clk;

  nmea_rx_arbiter #(.N_CH(N), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_char     (chr),
    .i_valid    (vld),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (rdy),
    .o_ch       (o_ch),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_overflow (o_overflow),
    .i_ovf_clr  (clr),
    .o_abort    (o_abort)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q_d[$];
  int         q_ch[$];
  logic       q_sop[$];
  logic       q_eop[$];
  int         q_cyc[$];
  int         n_abort;
  int         abort_cyc;
  int         t0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && rdy) begin
        q_d.push_back(o_data);
        q_ch.push_back(int'(o_ch));
        q_sop.push_back(o_sop);
        q_eop.push_back(o_eop);
        q_cyc.push_back(cyc);
      end
      if (o_abort) begin
        n_abort++;
        abort_cyc = cyc;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // exp_ch holds one decimal digit per expected character.
  task automatic chk_stream(input string tag, input string exp_d, input string exp_ch);
    int n;
    chk({tag, "_len"}, q_d.size(), exp_d.len());
    n = (q_d.size() < exp_d.len()) ? q_d.size() : exp_d.len();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_d%0d", tag, i), 32'(q_d[i]), 32'(exp_d[i]));
      chk($sformatf("%s_ch%0d", tag, i), q_ch[i], int'(exp_ch[i]) - 48);
      chk($sformatf("%s_sop%0d", tag, i), 32'(q_sop[i]), 32'(exp_d[i] == 8'h24));
      chk($sformatf("%s_eop%0d", tag, i), 32'(q_eop[i]), 32'(exp_d[i] == 8'h0A));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    chr = '0;
    rdy = 1'b1;
    clr = 1'b0;
    idle(2);
    rst = 1'b0;
    q_d.delete(); q_ch.delete(); q_sop.delete(); q_eop.delete(); q_cyc.delete();
    n_abort = 0;
    abort_cyc = 0;
  endtask

  task automatic send(input int ch, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (i == 0) t0 = cyc;
      vld[ch] = 1'b1;
      chr[ch] = s[i];
      idle(1);
      vld[ch] = 1'b0;
    end
  endtask

  task automatic send2(input int a, input int b, input string sa, input string sb);
    for (int i = 0; i < sa.len(); i++) begin
      vld[a] = 1'b1; chr[a] = sa[i];
      vld[b] = 1'b1; chr[b] = sb[i];
      idle(1);
      vld[a] = 1'b0; vld[b] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; vld = '0; chr = '0; rdy = 1'b1; clr = 1'b0;
    n_abort = 0; abort_cyc = 0; t0 = 0;
    do_reset();

    chk("rst_valid", o_valid, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_ch", o_ch, 0);
    chk("rst_sop", o_sop, 0);
    chk("rst_eop", o_eop, 0);
    chk("rst_abort", o_abort, 0);

    send(3, "$GPGGA*4E\r\n");
    idle(10);
    chk_stream("single", "$GPGGA*4E\r\n", "33333333333");
    if (q_cyc.size() > 0) chk("single_lat", q_cyc[0] - t0, 2);
    else chk("single_lat_none", 0, 1);
    chk("single_idle", dut.r_state, 0);

    do_reset();
    send2(0, 5, "$A\n", "$B\n");
    idle(12);
    chk_stream("contend", "$A\n$B\n", "000555");
    if (q_cyc.size() >= 4) chk("contend_gap", q_cyc[3] - q_cyc[2], 2);
    else chk("contend_gap_none", 0, 1);

    do_reset();
    send(7, "$\n");
    idle(6);
    send2(2, 8, "$\n", "$\n");
    idle(12);
    chk_stream("rr", "$\n$\n$\n", "778822");

    do_reset();
    send(2, "xyz$A\r\n");
    idle(10);
    chk_stream("garbage", "$A\r\n", "2222");

    do_reset();
    rdy = 1'b0;
    send(1, "$ABCDE");
    idle(3);
    chk("bp_valid", o_valid, 1);
    chk("bp_data", o_data, 8'h24);
    chk("bp_ch", o_ch, 1);
    chk("bp_sop", o_sop, 1);
    chk("bp_ovf", o_overflow, 10'h002);
    idle(3);
    chk("bp_hold", o_data, 8'h24);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("bp_clr", o_overflow, 0);
    rdy = 1'b1;
    send(1, "\n");
    idle(10);
    chk("bp_fullpush", o_overflow, 0);
    chk_stream("bp", "$ABC\n", "11111");

`ifdef NMEA_ARB_TIMEOUT_EN
    do_reset();
    send(4, "$GP");
    idle(25);
    chk("to_count", n_abort, 1);
    if (q_cyc.size() >= 3) chk("to_lat", abort_cyc - q_cyc[2], 17);
    else chk("to_lat_none", 0, 1);
    send(4, "$X\n");
    idle(8);
    chk_stream("to", "$GP$X\n", "444444");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
